arcade_input: RTL and testbench

ARCADE_INPUT -- requirements
Module: arcade_input

---
 rtl/arcade_input.sv | 113 +++++++++++
 tb/tb_arcade_input.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/arcade_input.sv
// arcade_input: merges PS/2 keys and joystick into active-low arcade buttons and runs a coin/start sequencer.
module arcade_input #(
    parameter int COIN_FRAMES  = 4,
    parameter int GAP_FRAMES   = 4,
    parameter int START_FRAMES = 4
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        rotate,
    input  logic        vblank,
    output logic [7:0]  button_n,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, COIN, GAP, START, RELEASE} state_t;
    state_t state, state_nx;
    logic armed, tog_q, ev, pr, ext;
    logic [7:0] code, cnt, cnt_nx;
    logic k_up, k_down, k_left, k_right, k_space, k_ctrl, k_f1, k_f2;
    logic m_up, m_down, m_left, m_right, d_up, d_down, d_left, d_right, fire;
    logic req1, req2, req1_q, req2_q, edge1, edge2, vb1, vb2, tick;
    logic sel, sel_nx, coin, st1, st2;
    logic [8:0] tcnt;
    logic unused_joy;
    assign unused_joy = ^joy[15:7];
    assign code = ps2_key[7:0];
    assign ext  = ps2_key[8];
    assign pr   = ps2_key[9];
    // armed stays low for the first clock after reset so the toggle is only sampled
    assign ev   = armed && (ps2_key[10] != tog_q);
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            {armed, tog_q, k_up, k_down, k_left, k_right} <= '0;
            {k_space, k_ctrl, k_f1, k_f2} <= '0;
        end else begin
            armed <= 1'b1;
            tog_q <= ps2_key[10];
            if (ev && code == 8'h75) k_up <= pr;
            if (ev && code == 8'h72) k_down <= pr;
            if (ev && code == 8'h6B) k_left <= pr;
            if (ev && code == 8'h74) k_right <= pr;
            if (ev && !ext && code == 8'h29) k_space <= pr;
            if (ev && !ext && code == 8'h14) k_ctrl <= pr;
            if (ev && !ext && code == 8'h05) k_f1 <= pr;
            if (ev && !ext && code == 8'h06) k_f2 <= pr;
        end
    end
    assign m_up    = k_up | joy[3];
    assign m_down  = k_down | joy[2];
    assign m_left  = k_left | joy[1];
    assign m_right = k_right | joy[0];
    assign d_up    = rotate ? m_left : m_up;
    assign d_down  = rotate ? m_right : m_down;
    assign d_left  = rotate ? m_down : m_left;
    assign d_right = rotate ? m_up : m_right;
    assign fire    = k_space | k_ctrl | joy[4];
    assign req1    = k_f1 | joy[5];
    assign req2    = k_f2 | joy[6];
    assign edge1   = req1 & ~req1_q;
    assign edge2   = req2 & ~req2_q;
    assign tick    = vb1 & ~vb2;
    assign tcnt    = {1'b0, cnt} + {8'd0, tick};
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        cnt_nx   = tcnt[7:0];
        case (state)
            IDLE: begin
                cnt_nx = 8'd0;
                if (edge1 | edge2) begin
                    state_nx = COIN;
                    sel_nx   = ~edge1;
                    cnt_nx   = {7'd0, tick};
                end
            end
            COIN:  if (tcnt >= 9'(COIN_FRAMES)) begin state_nx = GAP; cnt_nx = 8'd0; end
            GAP:   if (tcnt >= 9'(GAP_FRAMES)) begin state_nx = START; cnt_nx = 8'd0; end
            START: if (tcnt >= 9'(START_FRAMES)) begin state_nx = RELEASE; cnt_nx = 8'd0; end
            RELEASE: begin
                cnt_nx = 8'd0;
                if (!req1 && !req2) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end
    assign coin = state == COIN;
    assign st1  = state == START && !sel;
    assign st2  = state == START && sel;
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            sel      <= 1'b0;
            {req1_q, req2_q, vb1, vb2} <= '0;
            button_n <= 8'hFF;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            sel      <= sel_nx;
            req1_q   <= req1;
            req2_q   <= req2;
            vb1      <= vblank;
            vb2      <= vb1;
            button_n <= ~{st2, fire, coin, st1, d_right, d_left, d_down, d_up};
            busy     <= state_nx != IDLE;
        end
    end
endmodule

// File: tb/tb_arcade_input.sv
// tb_arcade_input: directed vectors with a cycle-stamped scoreboard checked by an independent monitor.
module tb_arcade_input;
    logic        clk_sys = 1'b0;
    logic        RESET_N;
    logic [10:0] ps2_key;
    logic [15:0] joy;
    logic        rotate, vblank;
    logic [7:0]  button_n;
    logic        busy;
    int cyc = 0, n_run = 0, n_fail = 0;
    typedef struct {int due; logic [7:0] bn; logic bz; string name;} exp_t;
    exp_t sb[$];

    arcade_input dut (
        .clk_sys(clk_sys), .RESET_N(RESET_N), .ps2_key(ps2_key), .joy(joy),
        .rotate(rotate), .vblank(vblank), .button_n(button_n), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_run++;
            if (button_n !== e.bn || busy !== e.bz) begin
                n_fail++;
                $display("FAIL %s: got button_n=%h busy=%b, expected button_n=%h busy=%b",
                         e.name, button_n, busy, e.bn, e.bz);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic expect_at(input int d, input logic [7:0] bn, input logic bz, input string nm);
        sb.push_back('{cyc + d, bn, bz, nm});
    endtask

    task automatic key(input logic p, input logic [8:0] c, input logic [7:0] bn, input string nm);
        ps2_key = {~ps2_key[10], p, c};
        expect_at(2, bn, 1'b0, nm);
        step(3);
    endtask

    task automatic joy_set(input logic r, input logic [15:0] j, input logic [7:0] bn, input string nm);
        rotate = r;
        joy = j;
        expect_at(1, bn, 1'b0, nm);
        step(2);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            vblank = 1'b1;
            step(1);
            vblank = 1'b0;
            step(7);
        end
    endtask

    initial begin
        RESET_N = 1'b0; ps2_key = '0; joy = '0; rotate = 1'b0; vblank = 1'b0;
        step(3);
        expect_at(0, 8'hFF, 1'b0, "reset");
        step(1);
        RESET_N = 1'b1;
        step(2);
        // keyboard directions, with exact two-cycle latency on the first press
        ps2_key = {~ps2_key[10], 1'b1, 9'h075};
        expect_at(1, 8'hFF, 1'b0, "up_lat1");
        expect_at(2, 8'hFE, 1'b0, "up_lat2");
        step(3);
        key(1'b0, 9'h075, 8'hFF, "up_rel");
        key(1'b1, 9'h172, 8'hFD, "down_ext");
        key(1'b0, 9'h172, 8'hFF, "down_rel");
        key(1'b1, 9'h06B, 8'hFB, "left");
        key(1'b0, 9'h06B, 8'hFF, "left_rel");
        key(1'b1, 9'h074, 8'hF7, "right");
        key(1'b0, 9'h074, 8'hFF, "right_rel");
        key(1'b1, 9'h01C, 8'hFF, "unknown_code");
        key(1'b1, 9'h129, 8'hFF, "space_ext_ignored");
        // fire held by either of two keys
        key(1'b1, 9'h029, 8'hBF, "space");
        key(1'b1, 9'h014, 8'hBF, "space_ctrl");
        key(1'b0, 9'h029, 8'hBF, "ctrl_holds");
        key(1'b0, 9'h014, 8'hFF, "fire_rel");
        // joystick with and without rotation
        joy_set(1'b0, 16'h0008, 8'hFE, "joy_up");
        joy_set(1'b1, 16'h0008, 8'hF7, "rot_up");
        joy_set(1'b1, 16'h0001, 8'hFD, "rot_right");
        joy_set(1'b1, 16'h0002, 8'hFE, "rot_left");
        joy_set(1'b1, 16'h0004, 8'hFB, "rot_down");
        joy_set(1'b0, 16'h0010, 8'hBF, "joy_fire");
        joy_set(1'b0, 16'h0000, 8'hFF, "joy_none");
        // full start2 sequence
        joy = 16'h0040;
        expect_at(1, 8'hFF, 1'b1, "s2_busy");
        expect_at(2, 8'hDF, 1'b1, "s2_coin");
        step(2);
        frames(3); expect_at(0, 8'hDF, 1'b1, "s2_coin3");
        frames(1); expect_at(0, 8'hFF, 1'b1, "s2_gap");
        frames(3); expect_at(0, 8'hFF, 1'b1, "s2_gap3");
        frames(1); expect_at(0, 8'h7F, 1'b1, "s2_start");
        frames(3); expect_at(0, 8'h7F, 1'b1, "s2_start3");
        frames(1); expect_at(0, 8'hFF, 1'b1, "s2_release");
        step(2);
        expect_at(0, 8'hFF, 1'b1, "s2_hold");
        joy = 16'h0000;
        expect_at(1, 8'hFF, 1'b0, "s2_idle");
        step(2);
        // simultaneous requests pick start1; a later edge during GAP is dropped
        joy = 16'h0060;
        expect_at(2, 8'hDF, 1'b1, "both_coin");
        step(2);
        frames(4); expect_at(0, 8'hFF, 1'b1, "both_gap");
        joy = 16'h0040;
        step(1);
        joy = 16'h0060;
        step(2);
        expect_at(0, 8'hFF, 1'b1, "gap_edge_ignored");
        frames(4); expect_at(0, 8'hEF, 1'b1, "both_start1");
        frames(4); expect_at(0, 8'hFF, 1'b1, "both_release");
        joy = 16'h0000;
        expect_at(2, 8'hFF, 1'b0, "both_idle");
        step(2);
        // reset during START, with a toggle level pending across reset release
        joy = 16'h0040;
        step(2);
        frames(8); expect_at(0, 8'h7F, 1'b1, "rst_start");
        step(1);
        RESET_N = 1'b0;
        expect_at(0, 8'hFF, 1'b0, "rst_async");
        ps2_key = {~ps2_key[10], 1'b1, 9'h075};
        step(2);
        joy = 16'h0000;
        RESET_N = 1'b1;
        step(4);
        expect_at(0, 8'hFF, 1'b0, "rst_no_event");
        step(1);
        key(1'b1, 9'h075, 8'hFE, "post_rst_up");
        key(1'b0, 9'h075, 8'hFF, "post_rst_rel");
        for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d checks pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
